wb_camera_fb: RTL
=================

# wb_camera_fb

Parametrised Wishbone camera capture peripheral with an on-chip frame buffer, used on the LM32 SoC Wishbone bus. It samples an OV7670-style parallel pixel stream (vsync/href/pclk/data) in the system clock domain and stores the top PIX_BITS of each pixel byte into a DEPTH-entry buffer. The CPU arms single-shot or continuous capture, polls status or takes an interrupt, and drains the buffer through an auto-incrementing data port.

## Interface
- DATA_W, 8: camera data bus width
- PIX_BITS, 4: stored bits per pixel, taken from data[DATA_W-1 -: PIX_BITS]; 1..DATA_W
- DEPTH, 1024: buffer entries (pixels); power of two
- ADDR_W, 10: log2(DEPTH)
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- wb_stb_i, wb_cyc_i, wb_we_i  in  1  Wishbone strobe/cycle/write
- wb_adr_i  in  32  byte address; only [3:0] decoded
- wb_sel_i  in  4  ignored; all accesses are full-word
- wb_dat_i  in  32  write data
- wb_dat_o  out  32  read data, registered
- wb_ack_o  out  1  = wb_stb_i & wb_cyc_i & ack_reg
- vsync, href, pclk  in  1  camera timing, asynchronous to clk
- data  in  DATA_W  camera pixel byte
- ready  out  1  a complete frame is in the buffer
- irq  out  1  = ready & irq_en

## Operation
- Input sync: vsync, href, pclk, data each pass two flops. Pixel strobe = synced pclk rising edge (rise detected one flop later). Requires f_clk ≥ 4·f_pclk.
- Registers (wb_adr_i[3:0]):
  - 0x0 CTRL/STATUS. Read: {27'h0, irq_en, cont, overflow, busy, ready}. Write: bit0 start (pulse), bit1 clear overflow/ready (pulse), bit2 cont, bit3 irq_en.
  - 0x4 DATA. Read returns {(32-PIX_BITS)'h0, buffer[rd_ptr]}; rd_ptr increments, wrapping DEPTH-1→0. Writes ignored.
  - 0x8 RDADDR. Write sets rd_ptr = wb_dat_i[ADDR_W-1:0]. Read returns rd_ptr zero-extended.
  - 0xC COUNT. Read: {frame_cnt[15:0], last_len[15:0]}, with last_len saturating at 16'hFFFF. Writes ignored.
- Capture FSM:
  - IDLE: busy=0. Start → ARM, which clears ready, wr_ptr and pix_cnt.
  - ARM: wait for a synced vsync falling edge (frame start) → CAPT.
  - CAPT: on each pixel strobe with synced href=1, if wr_ptr < DEPTH, write buffer[wr_ptr] and increment wr_ptr. Otherwise set overflow and drop the pixel. pix_cnt always increments.
  - On a synced vsync rising edge (frame end) → DONE.
  - DONE (1 cycle): ready=1, frame_cnt++, last_len=pix_cnt. If cont=1, go to ARM; otherwise go to IDLE.
- Start while busy: ignored. Clear and start in the same write: clear takes effect first, then start.
- cont=0 written while in CAPT: the current frame finishes, then the FSM goes to IDLE.
- Buffer: simple dual-port RAM with a synchronous read. Read address is rd_ptr. The prefetch register holds buffer[rd_ptr] one cycle after any rd_ptr change.
- Host reads during capture are allowed. They return whatever data is present, with no coherency guarantee.

## Timing
- Reset values:
  - ack_reg=0, wb_dat_o=0, ready=0, irq=0, busy=0, overflow=0, cont=0, irq_en=0.
  - rd_ptr=0, wr_ptr=0, frame_cnt=0, last_len=0, FSM=IDLE.
- Wishbone: ack_reg is set the cycle after stb&cyc&~ack_reg, so one wait state. It is cleared the following cycle. Back-to-back accesses are therefore ≥2 cycles apart, which keeps the prefetch valid.
- Register side-effects (pointer increment, CTRL pulses) fire in the same cycle as ack_reg is set, exactly once per access.
- Camera to buffer latency: a pixel is written 4 clk after the raw pclk rising edge (2 sync, 1 edge, 1 write).
- ready rises 1 cycle after the FSM enters DONE. irq follows ready combinationally.
- Reset asserted mid-capture: all state returns to its reset value on the next edge. Buffer contents are undefined afterwards.
- frame_cnt wraps at 16 bits. rd_ptr and wr_ptr are ADDR_W bits.

## Test plan
- Reset: assert reset for 3 cycles → every register reads 0, ready=0, irq=0, wb_ack_o=0.
- Single frame: write CTRL=0x1, then send 1 frame of 4 lines × 8 pixels with data=8'hA0+n → ready=1, COUNT=0x0001_0020. After RDADDR=0, 32 DATA reads return 0xA, 0xA, …, 0xB in order.
- Overflow: DEPTH=16, send a frame of 40 pixels → overflow=1, last_len=40, buffer holds pixels 0..15. Write CTRL=0x2 → overflow=0, ready=0.
- Continuous mode and irq: write CTRL=0xD, send 3 frames → frame_cnt=3, irq high after frame 1. Write CTRL=0x2 → irq drops in the cycle after ack.
- Pointer wrap: DEPTH=16, RDADDR=15, 2 DATA reads → entries 15 and 0 returned, RDADDR reads 1.
- Mid-frame arm and start-while-busy: start issued while vsync is low and href is toggling → no pixels stored until the next vsync falling edge. A second start during CAPT leaves frame_cnt and pix_cnt unaffected.

Source files
------------

// File: rtl/wb_camera_fb_if.sv
// Wishbone slave bus bundle for the camera frame-buffer peripheral.
// The LM32 side acts as master; the peripheral uses the slave modport.
interface wb_camera_fb_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_camera_fb.sv
// Wishbone camera capture peripheral: samples a parallel pixel stream into an
// on-chip buffer, with single-shot/continuous capture and auto-increment readout.
module wb_camera_fb #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned PIX_BITS = 4,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  wb_camera_fb_if.slave     wb,
  input  logic              vsync,
  input  logic              href,
  input  logic              pclk,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              irq
);

  localparam int unsigned PW = ADDR_W + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_CAPT, ST_DONE} state_t;

  state_t r_state, w_next;

  logic r_vs_s1, r_vs_s2, r_vs_d, r_vs_rise, r_vs_fall;
  logic r_hr_s1, r_hr_s2, r_hr_s3;
  logic r_pc_s1, r_pc_s2, r_pc_d, r_pix_stb;
  logic [DATA_W-1:0] r_d_s1, r_d_s2, r_d_s3;

  logic          r_ack, r_ready, r_ovf, r_cont, r_irq_en;
  logic [31:0]   r_dat_o, w_rdata;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [15:0]   r_pix_cnt, r_frame_cnt, r_last_len;
  logic [PIX_BITS-1:0] r_mem [DEPTH];
  logic [PIX_BITS-1:0] r_rd_data;

  logic       w_acc, w_wr, w_rd, w_ctrl_wr, w_start, w_clear, w_data_rd, w_rdaddr_wr;
  logic [3:0] w_adr;
  logic       w_busy, w_arm, w_done, w_pix, w_full, w_we;
  logic       w_unused;

  // Two-flop synchronisers; edge strobes are registered so data/href stay aligned
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vs_s1 <= 1'b0; r_vs_s2 <= 1'b0; r_vs_d <= 1'b0;
      r_vs_rise <= 1'b0; r_vs_fall <= 1'b0;
      r_hr_s1 <= 1'b0; r_hr_s2 <= 1'b0; r_hr_s3 <= 1'b0;
      r_pc_s1 <= 1'b0; r_pc_s2 <= 1'b0; r_pc_d <= 1'b0; r_pix_stb <= 1'b0;
      r_d_s1 <= '0; r_d_s2 <= '0; r_d_s3 <= '0;
    end else begin
      r_vs_s1 <= vsync; r_vs_s2 <= r_vs_s1; r_vs_d <= r_vs_s2;
      r_vs_rise <= r_vs_s2 & ~r_vs_d;
      r_vs_fall <= ~r_vs_s2 & r_vs_d;
      r_hr_s1 <= href;  r_hr_s2 <= r_hr_s1; r_hr_s3 <= r_hr_s2;
      r_pc_s1 <= pclk;  r_pc_s2 <= r_pc_s1; r_pc_d <= r_pc_s2;
      r_pix_stb <= r_pc_s2 & ~r_pc_d;
      r_d_s1 <= data;   r_d_s2 <= r_d_s1;   r_d_s3 <= r_d_s2;
    end
  end

  // Bus decode: one access per stb/cyc, side effects on the cycle ack is set
  assign w_acc       = wb.wb_stb_i & wb.wb_cyc_i & ~r_ack;
  assign w_adr       = wb.wb_adr_i[3:0];
  assign w_wr        = w_acc & wb.wb_we_i;
  assign w_rd        = w_acc & ~wb.wb_we_i;
  assign w_ctrl_wr   = w_wr && (w_adr == 4'h0);
  assign w_start     = w_ctrl_wr & wb.wb_dat_i[0];
  assign w_clear     = w_ctrl_wr & wb.wb_dat_i[1];
  assign w_data_rd   = w_rd && (w_adr == 4'h4);
  assign w_rdaddr_wr = w_wr && (w_adr == 4'h8);
  assign wb.wb_ack_o = wb.wb_stb_i & wb.wb_cyc_i & r_ack;
  assign wb.wb_dat_o = r_dat_o;
  assign ready       = r_ready;
  assign irq         = r_ready & r_irq_en;
  assign w_unused    = ^{wb.wb_sel_i, wb.wb_adr_i[31:4], r_d_s3};

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_start)   w_next = ST_ARM;
      ST_ARM:  if (r_vs_fall) w_next = ST_CAPT;
      ST_CAPT: if (r_vs_rise) w_next = ST_DONE;
      ST_DONE: w_next = r_cont ? ST_ARM : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_arm  = 1'b0;
    w_done = 1'b0;
    w_pix  = 1'b0;
    w_busy = (r_state != ST_IDLE);
    w_arm  = (r_state != ST_ARM) && (w_next == ST_ARM);
    w_done = (r_state == ST_DONE);
    w_pix  = (r_state == ST_CAPT) && r_pix_stb && r_hr_s3;
  end

  assign w_full = r_wr_ptr[ADDR_W];
  assign w_we   = w_pix & ~w_full;

  always_comb begin
    case (w_adr)
      4'h0:    w_rdata = 32'({r_irq_en, r_cont, r_ovf, w_busy, r_ready});
      4'h4:    w_rdata = 32'(r_rd_data);
      4'h8:    w_rdata = 32'(r_rd_ptr);
      4'hC:    w_rdata = {r_frame_cnt, r_last_len};
      default: w_rdata = 32'h0;
    endcase
  end

  // Control/status and pointer state; later assignments win (clear before start)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ack <= 1'b0; r_dat_o <= 32'h0; r_ready <= 1'b0; r_ovf <= 1'b0;
      r_cont <= 1'b0; r_irq_en <= 1'b0; r_rd_ptr <= '0; r_wr_ptr <= '0;
      r_pix_cnt <= 16'h0; r_frame_cnt <= 16'h0; r_last_len <= 16'h0;
    end else begin
      r_ack <= w_acc;
      if (w_rd) r_dat_o <= w_rdata;
      if (w_ctrl_wr) begin
        r_cont   <= wb.wb_dat_i[2];
        r_irq_en <= wb.wb_dat_i[3];
      end
      if (w_clear) begin
        r_ready <= 1'b0;
        r_ovf   <= 1'b0;
      end
      if (w_arm) begin
        r_wr_ptr  <= '0;
        r_pix_cnt <= 16'h0;
        if (r_state == ST_IDLE) r_ready <= 1'b0;
      end
      if (w_done) begin
        r_ready     <= 1'b1;
        r_frame_cnt <= r_frame_cnt + 16'd1;
        r_last_len  <= r_pix_cnt;
      end
      if (w_pix) begin
        if (w_full) r_ovf    <= 1'b1;
        else        r_wr_ptr <= r_wr_ptr + PW'(1);
        if (r_pix_cnt != 16'hFFFF) r_pix_cnt <= r_pix_cnt + 16'd1;
      end
      if (w_rdaddr_wr)    r_rd_ptr <= wb.wb_dat_i[ADDR_W-1:0];
      else if (w_data_rd) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
    end
  end

  // Pixel buffer with registered read port prefetching buffer[rd_ptr]
  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_wr_ptr[ADDR_W-1:0]] <= r_d_s3[DATA_W-1 -: PIX_BITS];
    r_rd_data <= r_mem[r_rd_ptr];
  end

endmodule
